// File: rtl/uart_arb_pkg.sv
// Shared types and constants for the two-master UART slave-port arbiter.
package uart_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  localparam logic [31:0] ERR_RDATA = 32'hFFFF_FFFF;

endpackage

// File: rtl/uart_mem_arbiter_if.sv
// picorv32-style native memory bus; the err line is only meaningful towards a master.
interface uart_mem_arbiter_if;
  logic        mem_valid;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic        mem_err;

  modport master (
    output mem_valid, mem_addr, mem_wdata, mem_wstrb,
    input  mem_ready, mem_rdata
  );

  modport slave (
    input  mem_valid, mem_addr, mem_wdata, mem_wstrb,
    output mem_ready, mem_rdata, mem_err
  );
endinterface

// File: rtl/uart_mem_arbiter.sv
// Round-robin arbiter sharing the UART slave port between two bus masters,
// with a per-transfer stall timeout that completes the transfer with an error.
module uart_mem_arbiter
  import uart_arb_pkg::*;
#(
  parameter int unsigned TIMEOUT   = 1024,
  parameter logic [23:0] ADDR_BASE = 24'h800000
) (
  input  logic                clk,
  input  logic                resetn,
  uart_mem_arbiter_if.slave   m0,
  uart_mem_arbiter_if.slave   m1,
  uart_mem_arbiter_if.master  s,
  output logic                timeout_pulse
);

  localparam int unsigned CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  state_t         state, state_next;
  logic           last_grant;
  logic           gnt;
  logic [CW-1:0]  cnt;
  logic [31:0]    rdata_q;
  logic           err_q;
  logic           req0, req1, pick, timeout_hit;

  // Tie goes to the master that was not served last; otherwise the lone requester.
  function automatic logic rr_pick(input logic r0, input logic r1, input logic last);
    if (r0 && r1) return ~last;
    return r1;
  endfunction

  assign req0        = m0.mem_valid && (m0.mem_addr[31:8] == ADDR_BASE);
  assign req1        = m1.mem_valid && (m1.mem_addr[31:8] == ADDR_BASE);
  assign pick        = rr_pick(req0, req1, last_grant);
  assign timeout_hit = (TIMEOUT != 0) && (cnt == CW'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state       <= ST_IDLE;
      last_grant  <= 1'b1;
      gnt         <= 1'b0;
      cnt         <= '0;
      rdata_q     <= '0;
      err_q       <= 1'b0;
      s.mem_valid <= 1'b0;
      s.mem_addr  <= '0;
      s.mem_wdata <= '0;
      s.mem_wstrb <= '0;
    end else begin
      state <= state_next;
      case (state)
        ST_IDLE: begin
          if (req0 || req1) begin
            gnt         <= pick;
            last_grant  <= pick;
            cnt         <= '0;
            s.mem_valid <= 1'b1;
            s.mem_addr  <= pick ? m1.mem_addr  : m0.mem_addr;
            s.mem_wdata <= pick ? m1.mem_wdata : m0.mem_wdata;
            s.mem_wstrb <= pick ? m1.mem_wstrb : m0.mem_wstrb;
          end
        end
        ST_BUSY: begin
          // Slave ready takes priority over a coincident timeout.
          if (s.mem_ready) begin
            rdata_q     <= s.mem_rdata;
            err_q       <= 1'b0;
            s.mem_valid <= 1'b0;
            cnt         <= '0;
          end else if (timeout_hit) begin
            rdata_q     <= ERR_RDATA;
            err_q       <= 1'b1;
            s.mem_valid <= 1'b0;
            cnt         <= '0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_next    = state;
    m0.mem_ready  = 1'b0;
    m0.mem_rdata  = '0;
    m0.mem_err    = 1'b0;
    m1.mem_ready  = 1'b0;
    m1.mem_rdata  = '0;
    m1.mem_err    = 1'b0;
    timeout_pulse = 1'b0;
    case (state)
      ST_IDLE: if (req0 || req1) state_next = ST_BUSY;
      ST_BUSY: if (s.mem_ready || timeout_hit) state_next = ST_RESP;
      ST_RESP: begin
        state_next    = ST_IDLE;
        timeout_pulse = err_q;
        if (gnt) begin
          m1.mem_ready = 1'b1;
          m1.mem_rdata = rdata_q;
          m1.mem_err   = err_q;
        end else begin
          m0.mem_ready = 1'b1;
          m0.mem_rdata = rdata_q;
          m0.mem_err   = err_q;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_uart_mem_arbiter.sv
// Directed bench for uart_mem_arbiter with TIMEOUT=16; all driving and sampling
// happens 1 time unit after each rising edge, so "cycle n" is the period after edge n.
module tb_uart_mem_arbiter;

  logic clk = 1'b0;
  logic resetn;
  logic timeout_pulse;
  int   tests  = 0;
  int   failed = 0;
  int   acc_a, acc_b;

  uart_mem_arbiter_if m0_bus ();
  uart_mem_arbiter_if m1_bus ();
  uart_mem_arbiter_if s_bus ();

  uart_mem_arbiter #(.TIMEOUT(16), .ADDR_BASE(24'h800000)) dut (
    .clk           (clk),
    .resetn        (resetn),
    .m0            (m0_bus.slave),
    .m1            (m1_bus.slave),
    .s             (s_bus.master),
    .timeout_pulse (timeout_pulse)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    end
  endtask

  task automatic m0_req(input logic v, input logic [31:0] a, input logic [31:0] d, input logic [3:0] w);
    m0_bus.mem_valid = v; m0_bus.mem_addr = a; m0_bus.mem_wdata = d; m0_bus.mem_wstrb = w;
  endtask

  task automatic m1_req(input logic v, input logic [31:0] a, input logic [31:0] d, input logic [3:0] w);
    m1_bus.mem_valid = v; m1_bus.mem_addr = a; m1_bus.mem_wdata = d; m1_bus.mem_wstrb = w;
  endtask

  initial begin
    resetn = 1'b0;
    m0_req(1'b0, '0, '0, '0);
    m1_req(1'b0, '0, '0, '0);
    s_bus.mem_ready = 1'b0;
    s_bus.mem_rdata = '0;
    s_bus.mem_err   = 1'b0;
    step(); step();

    // Reset state
    chk("rst_m0_ready", 32'(m0_bus.mem_ready), 32'd0);
    chk("rst_m1_ready", 32'(m1_bus.mem_ready), 32'd0);
    chk("rst_m0_rdata", m0_bus.mem_rdata, 32'd0);
    chk("rst_s_valid",  32'(s_bus.mem_valid), 32'd0);
    chk("rst_s_addr",   s_bus.mem_addr, 32'd0);
    chk("rst_tpulse",   32'(timeout_pulse), 32'd0);
    resetn = 1'b1;
    step();

    // m0 write 0x41 to 0x8000_0004, slave ready in cycle 2
    m0_req(1'b1, 32'h8000_0004, 32'h0000_0041, 4'h1);
    s_bus.mem_rdata = 32'h1234_5678;
    step(); // cycle 1
    chk("wr_s_valid", 32'(s_bus.mem_valid), 32'd1);
    chk("wr_s_wdata", s_bus.mem_wdata, 32'h41);
    chk("wr_s_addr",  s_bus.mem_addr, 32'h8000_0004);
    chk("wr_s_wstrb", 32'(s_bus.mem_wstrb), 32'h1);
    m0_bus.mem_wdata = 32'hAAAA_AAAA;
    step(); // cycle 2
    chk("wr_hold_wdata", s_bus.mem_wdata, 32'h41);
    chk("wr_m0_ready_c2", 32'(m0_bus.mem_ready), 32'd0);
    s_bus.mem_ready = 1'b1;
    step(); // cycle 3
    s_bus.mem_ready = 1'b0;
    chk("wr_m0_ready_c3", 32'(m0_bus.mem_ready), 32'd1);
    chk("wr_m0_err",      32'(m0_bus.mem_err), 32'd0);
    chk("wr_m1_ready",    32'(m1_bus.mem_ready), 32'd0);
    chk("wr_s_valid_low", 32'(s_bus.mem_valid), 32'd0);
    m0_req(1'b0, '0, '0, '0);
    step(); // cycle 4
    chk("wr_m0_ready_c4", 32'(m0_bus.mem_ready), 32'd0);
    chk("wr_s_valid_c4",  32'(s_bus.mem_valid), 32'd0);

    // Tie right after reset: m0, then m1, then m0 again
    resetn = 1'b0;
    step();
    resetn = 1'b1;
    m0_req(1'b1, 32'h8000_0008, '0, 4'h0);
    m1_req(1'b1, 32'h8000_0008, '0, 4'h0);
    step(); // cycle 1
    chk("tie1_s_valid", 32'(s_bus.mem_valid), 32'd1);
    step(); // cycle 2
    s_bus.mem_ready = 1'b1; s_bus.mem_rdata = 32'h1111_1111;
    step(); // cycle 3
    s_bus.mem_ready = 1'b0;
    chk("tie1_m0_ready", 32'(m0_bus.mem_ready), 32'd1);
    chk("tie1_m0_rdata", m0_bus.mem_rdata, 32'h1111_1111);
    chk("tie1_m1_ready", 32'(m1_bus.mem_ready), 32'd0);
    chk("tie1_m1_rdata", m1_bus.mem_rdata, 32'd0);
    m0_req(1'b0, '0, '0, '0);
    step(); // cycle 4: idle, m1 still requesting
    chk("tie2_gap_s_valid", 32'(s_bus.mem_valid), 32'd0);
    step(); // cycle 5
    chk("tie2_s_valid", 32'(s_bus.mem_valid), 32'd1);
    step(); // cycle 6
    s_bus.mem_ready = 1'b1; s_bus.mem_rdata = 32'h2222_2222;
    step(); // cycle 7
    s_bus.mem_ready = 1'b0;
    chk("tie2_m1_ready", 32'(m1_bus.mem_ready), 32'd1);
    chk("tie2_m1_rdata", m1_bus.mem_rdata, 32'h2222_2222);
    chk("tie2_m0_ready", 32'(m0_bus.mem_ready), 32'd0);
    m1_req(1'b0, '0, '0, '0);
    step(); // cycle 8: second tie
    m0_req(1'b1, 32'h8000_0008, '0, 4'h0);
    m1_req(1'b1, 32'h8000_0008, '0, 4'h0);
    step(); step(); // cycle 10
    s_bus.mem_ready = 1'b1; s_bus.mem_rdata = 32'h3333_3333;
    step(); // cycle 11
    s_bus.mem_ready = 1'b0;
    chk("tie3_m0_ready", 32'(m0_bus.mem_ready), 32'd1);
    chk("tie3_m1_ready", 32'(m1_bus.mem_ready), 32'd0);
    m0_req(1'b0, '0, '0, '0);
    m1_req(1'b0, '0, '0, '0);
    step(); step();

    // Timeout: m1 read, slave never ready
    m1_req(1'b1, 32'h8000_0010, '0, 4'h0);
    acc_a = 0; acc_b = 0;
    for (int i = 1; i <= 16; i++) begin
      step();
      acc_a += int'(s_bus.mem_valid);
      acc_b += int'(m1_bus.mem_ready) + int'(timeout_pulse);
    end
    chk("to_busy_cycles", 32'(acc_a), 32'd16);
    chk("to_early_ready", 32'(acc_b), 32'd0);
    step(); // cycle 17
    chk("to_s_valid",  32'(s_bus.mem_valid), 32'd0);
    chk("to_m1_ready", 32'(m1_bus.mem_ready), 32'd1);
    chk("to_m1_rdata", m1_bus.mem_rdata, 32'hFFFF_FFFF);
    chk("to_m1_err",   32'(m1_bus.mem_err), 32'd1);
    chk("to_pulse",    32'(timeout_pulse), 32'd1);
    chk("to_m0_ready", 32'(m0_bus.mem_ready), 32'd0);
    m1_req(1'b0, '0, '0, '0);
    step(); // cycle 18
    chk("to_pulse_off", 32'(timeout_pulse), 32'd0);
    chk("to_err_off",   32'(m1_bus.mem_err), 32'd0);
    step();

    // Slave ready exactly at cnt == TIMEOUT-1 (cycle 16)
    m0_req(1'b1, 32'h8000_0000, '0, 4'h0);
    for (int i = 1; i <= 16; i++) step();
    s_bus.mem_ready = 1'b1; s_bus.mem_rdata = 32'hCAFE_0001;
    step(); // cycle 17
    s_bus.mem_ready = 1'b0;
    chk("edge_m0_ready", 32'(m0_bus.mem_ready), 32'd1);
    chk("edge_m0_err",   32'(m0_bus.mem_err), 32'd0);
    chk("edge_m0_rdata", m0_bus.mem_rdata, 32'hCAFE_0001);
    chk("edge_pulse",    32'(timeout_pulse), 32'd0);
    m0_req(1'b0, '0, '0, '0);
    step(); step();

    // Out-of-window request is never granted
    m0_req(1'b1, 32'h8000_1004, 32'h0000_0099, 4'hF);
    acc_a = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      acc_a += int'(s_bus.mem_valid) + int'(m0_bus.mem_ready);
    end
    chk("oow_no_grant", 32'(acc_a), 32'd0);
    m0_req(1'b0, '0, '0, '0);
    step();

    // Reset during BUSY, then a fresh m1 request
    m0_req(1'b1, 32'h8000_0004, 32'h0000_0077, 4'h1);
    step(); // cycle 1
    chk("rb_s_valid", 32'(s_bus.mem_valid), 32'd1);
    step(); // cycle 2
    resetn = 1'b0;
    m0_req(1'b0, '0, '0, '0);
    step(); // cycle 3
    chk("rb_s_valid_drop", 32'(s_bus.mem_valid), 32'd0);
    chk("rb_s_addr",       s_bus.mem_addr, 32'd0);
    chk("rb_m0_ready",     32'(m0_bus.mem_ready), 32'd0);
    chk("rb_m0_err",       32'(m0_bus.mem_err), 32'd0);
    resetn = 1'b1;
    m1_req(1'b1, 32'h8000_0000, 32'h0000_0055, 4'h1);
    step(); // cycle 4
    chk("rb_m1_s_valid", 32'(s_bus.mem_valid), 32'd1);
    chk("rb_m1_s_wdata", s_bus.mem_wdata, 32'h55);
    step(); // cycle 5
    s_bus.mem_ready = 1'b1;
    step(); // cycle 6
    s_bus.mem_ready = 1'b0;
    chk("rb_m1_ready", 32'(m1_bus.mem_ready), 32'd1);
    chk("rb_m1_err",   32'(m1_bus.mem_err), 32'd0);
    chk("rb_m0_quiet", 32'(m0_bus.mem_ready), 32'd0);
    m1_req(1'b0, '0, '0, '0);
    step();

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
